// File: rtl/mcdp_pkg.sv
// mcdp_pkg: shared constants for the multi-cycle datapath.
// Holds opcodes, ALU functs, FSM states and instruction field positions.
package mcdp_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_LW   = 4'd2;
   localparam logic [3:0] OP_SW   = 4'd3;
   localparam logic [3:0] OP_BEQ  = 4'd4;
   localparam logic [3:0] OP_J    = 4'd5;
   localparam logic [3:0] OP_HALT = 4'd6;

   localparam logic [2:0] F_ADD = 3'd0;
   localparam logic [2:0] F_SUB = 3'd1;
   localparam logic [2:0] F_AND = 3'd2;
   localparam logic [2:0] F_OR  = 3'd3;
   localparam logic [2:0] F_SLT = 3'd4;

   localparam int OP_LSB = 12;
   localparam int RS_LSB = 9;
   localparam int RT_LSB = 6;
   localparam int RD_LSB = 3;
   localparam int FN_LSB = 0;
   localparam int IMM_W  = 6;
   localparam int TGT_W  = 12;

endpackage

// File: rtl/mcdp_regfile.sv
// mcdp_regfile: 8 x WIDTH register file, r0 hard-wired to zero.
// Ports: clk_i, rst_n_i, ra_i/rb_i -> rda_o/rdb_o (async), we_i/wa_i/wd_i (sync).
module mcdp_regfile #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [2:0]       ra_i,
   input  logic [2:0]       rb_i,
   output logic [WIDTH-1:0] rda_o,
   output logic [WIDTH-1:0] rdb_o,
   input  logic             we_i,
   input  logic [2:0]       wa_i,
   input  logic [WIDTH-1:0] wd_i
);

   logic [WIDTH-1:0] rf_q [8];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (we_i && wa_i != 3'd0) begin
         rf_q[wa_i] <= wd_i;
      end
   end

   assign rda_o = (ra_i == 3'd0) ? '0 : rf_q[ra_i];
   assign rdb_o = (rb_i == 3'd0) ? '0 : rf_q[rb_i];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle 16-bit-instruction core, FETCH/DECODE/EXEC/MEM/WB.
// Ports: clk, reset (async low), imem_* fetch port, dmem_* data port, halted, illegal.
module mc_datapath
   import mcdp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PC_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ready,
   input  logic [15:0]      imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   input  logic [WIDTH-1:0] dmem_rdata,
   input  logic             dmem_ready,
   output logic             halted,
   output logic             illegal
);

   state_t           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [15:0]      ir_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic             ill_q;

   logic [3:0]       op;
   logic [2:0]       rs, rt, rd, fn, wa;
   logic             is_mem;
   logic [WIDTH-1:0] imm_w, opb, alu_d;
   logic [WIDTH-1:0] rda, rdb;
   logic [PC_W-1:0]  imm_pc, tgt;

   assign op     = ir_q[OP_LSB +: 4];
   assign rs     = ir_q[RS_LSB +: 3];
   assign rt     = ir_q[RT_LSB +: 3];
   assign rd     = ir_q[RD_LSB +: 3];
   assign fn     = ir_q[FN_LSB +: 3];
   assign is_mem = (op == OP_LW) || (op == OP_SW);
   assign imm_w  = WIDTH'($signed(ir_q[IMM_W-1:0]));
   assign imm_pc = PC_W'($signed(ir_q[IMM_W-1:0]));
   assign tgt    = PC_W'(ir_q[TGT_W-1:0]);
   assign wa     = (op == OP_R) ? rd : rt;

   mcdp_regfile #(.WIDTH(WIDTH)) u_rf (
      .clk_i   (clk),
      .rst_n_i (reset),
      .ra_i    (rs),
      .rb_i    (rt),
      .rda_o   (rda),
      .rdb_o   (rdb),
      .we_i    (state_q == S_WB),
      .wa_i    (wa),
      .wd_i    (res_q)
   );

   always_comb begin
      opb   = (op == OP_ADDI || is_mem) ? imm_w : b_q;
      alu_d = a_q + opb;
      if (op == OP_R) begin
         case (fn)
            F_ADD:   alu_d = a_q + b_q;
            F_SUB:   alu_d = a_q - b_q;
            F_AND:   alu_d = a_q & b_q;
            F_OR:    alu_d = a_q | b_q;
            F_SLT:   alu_d = WIDTH'($signed(a_q) < $signed(b_q));
            default: alu_d = a_q + b_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  ir_q    <= imem_rdata;
                  pc_q    <= pc_q + PC_W'(1);
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q <= rda;
               b_q <= rdb;
               if (op == OP_HALT) begin
                  state_q <= S_HALT;
               end else if (op > OP_HALT) begin
                  ill_q   <= 1'b1;
                  state_q <= S_HALT;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_q <= alu_d;
               unique case (1'b1)
                  op == OP_BEQ: begin
                     if (a_q == b_q) pc_q <= pc_q + imm_pc;
                     state_q <= S_FETCH;
                  end
                  op == OP_J: begin
                     pc_q    <= tgt;
                     state_q <= S_FETCH;
                  end
                  is_mem:  state_q <= S_MEM;
                  default: state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (op == OP_LW) begin
                     res_q   <= dmem_rdata;
                     state_q <= S_WB;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end
            end
            S_WB:    state_q <= S_FETCH;
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_HALT;
         endcase
      end
   end

   // Reset forces state to FETCH, so the fetch request is also gated by reset.
   assign imem_req   = reset && (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM);
   assign dmem_we    = dmem_req && (op == OP_SW);
   assign dmem_addr  = res_q;
   assign dmem_wdata = b_q;
   assign halted     = (state_q == S_HALT);
   assign illegal    = ill_q;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: table-driven programs plus handshake/reset sequences.
// Runs mc_datapath with WIDTH=16, PC_W=8 against behavioural memories.
module tb_mc_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_ready;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        halted, illegal;

   mc_datapath #(.WIDTH(16), .PC_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ready (dmem_ready),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   localparam logic [15:0] H = 16'h6000;

   logic [15:0] imem [256];
   logic [15:0] drom [256];
   int dwait = 0;
   int dcnt = 0;
   int nst = 0;
   int overlap = 0;
   logic [15:0] st_data, st_addr;

   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = drom[dmem_addr[7:0]];
   assign dmem_ready = dmem_req && (dcnt >= dwait);

   always @(posedge clk) begin
      if (dmem_req && dmem_ready && dmem_we) begin
         nst     <= nst + 1;
         st_data <= dmem_wdata;
         st_addr <= dmem_addr;
      end
      dcnt <= (!dmem_req || dmem_ready) ? 0 : dcnt + 1;
   end

   always @(negedge clk)
      if (imem_req && dmem_req) overlap <= overlap + 1;

   typedef struct {
      string       name;
      logic [15:0] p [5];
      int          cyc;
      int          nst;
      logic [15:0] data;
      logic [15:0] addr;
      logic        ill;
   } vec_t;

   vec_t tbl [$];
   int errors = 0;
   int checks = 0;

   function automatic logic [15:0] er(int f, int rs, int rt, int rd);
      return {4'd0, 3'(rs), 3'(rt), 3'(rd), 3'(f)};
   endfunction

   function automatic logic [15:0] ei(int op, int rs, int rt, int imm);
      return {4'(op), 3'(rs), 3'(rt), 6'(imm)};
   endfunction

   function automatic logic [15:0] ej(int t);
      return {4'd5, 12'(t)};
   endfunction

   task automatic addv(string n,
                       logic [15:0] p0, logic [15:0] p1,
                       logic [15:0] p2, logic [15:0] p3,
                       logic [15:0] p4, int cyc, int ns,
                       logic [15:0] d, logic [15:0] a,
                       logic ill);
      vec_t v;
      v.name = n;
      v.p[0] = p0; v.p[1] = p1; v.p[2] = p2;
      v.p[3] = p3; v.p[4] = p4;
      v.cyc = cyc; v.nst = ns;
      v.data = d; v.addr = a; v.ill = ill;
      tbl.push_back(v);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load(logic [15:0] p [5]);
      for (int i = 0; i < 256; i++) imem[i] = H;
      for (int i = 0; i < 5; i++) imem[i] = p[i];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves reset released just after a falling edge.
   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run(input int maxc, output int cyc);
      cyc = 0;
      do_reset();
      while (cyc < maxc) begin
         tick();
         cyc++;
         if (halted) break;
      end
   endtask

   initial begin
      int cyc, base, cnt, bad, seen;
      logic [15:0] prog [5];

      imem_ready = 1'b1;
      for (int i = 0; i < 256; i++) drom[i] = 16'h0;
      drom[4] = 16'h8000;
      drom[5] = 16'hFFFF;

      addv("req35", ei(1,0,1,5), ei(1,0,2,-3), er(0,1,2,3), H, H,
           14, 0, 16'h0, 16'h0, 1'b0);
      addv("add", ei(1,0,1,5), ei(1,0,2,-3), er(0,1,2,3),
           ei(3,0,3,0), H, 18, 1, 16'h0002, 16'h0, 1'b0);
      addv("sub", ei(1,0,1,5), ei(1,0,2,7), er(1,1,2,3),
           ei(3,0,3,1), H, 18, 1, 16'hFFFE, 16'h1, 1'b0);
      addv("and", ei(1,0,1,12), ei(1,0,2,10), er(2,1,2,3),
           ei(3,0,3,3), H, 18, 1, 16'h0008, 16'h3, 1'b0);
      addv("or", ei(1,0,1,12), ei(1,0,2,10), er(3,1,2,3),
           ei(3,0,3,2), H, 18, 1, 16'h000E, 16'h2, 1'b0);
      addv("slt_neg", ei(2,0,1,4), ei(1,0,2,1), er(4,1,2,3),
           ei(3,0,3,0), H, 19, 1, 16'h0001, 16'h0, 1'b0);
      addv("slt_pos", ei(2,0,1,4), ei(1,0,2,1), er(4,2,1,3),
           ei(3,0,3,0), H, 19, 1, 16'h0000, 16'h0, 1'b0);
      addv("wrap", ei(2,0,1,5), ei(1,0,2,1), er(0,1,2,3),
           ei(3,0,3,0), H, 19, 1, 16'h0000, 16'h0, 1'b0);
      addv("r0_write", ei(1,0,0,5), ei(3,0,0,0), H, H, H,
           10, 1, 16'h0000, 16'h0, 1'b0);
      addv("funct7", ei(1,0,1,5), ei(1,0,2,7), er(7,1,2,3),
           ei(3,0,3,0), H, 18, 1, 16'h000C, 16'h0, 1'b0);
      addv("illegal", 16'hE000, H, H, H, H,
           2, 0, 16'h0, 16'h0, 1'b1);
      addv("beq_t", ei(1,0,2,7), ei(4,0,0,1), ei(1,0,2,9),
           ei(3,0,2,0), H, 13, 1, 16'h0007, 16'h0, 1'b0);
      addv("beq_nt", ei(1,0,1,3), ei(4,1,0,1), ei(1,0,2,9),
           ei(3,0,2,0), H, 17, 1, 16'h0009, 16'h0, 1'b0);
      addv("jump", ei(1,0,2,6), ej(3), ei(1,0,2,9),
           ei(3,0,2,0), H, 13, 1, 16'h0006, 16'h0, 1'b0);
      addv("sw_off", ei(1,0,1,20), ei(1,0,2,5), ei(3,2,1,-1),
           H, H, 14, 1, 16'h0014, 16'h4, 1'b0);

      // Reset state
      #2 reset = 1'b0;
      #1;
      chk("rst imem_req", imem_req, 1'b0);
      chk("rst dmem_req", dmem_req, 1'b0);
      chk("rst dmem_we", dmem_we, 1'b0);
      chk("rst halted", halted, 1'b0);
      chk("rst illegal", illegal, 1'b0);
      chk("rst imem_addr", imem_addr, 8'h00);

      foreach (tbl[k]) begin
         load(tbl[k].p);
         base = nst;
         run(60, cyc);
         chk({tbl[k].name, " halted"}, halted, 1'b1);
         chk({tbl[k].name, " cycles"}, cyc, tbl[k].cyc);
         chk({tbl[k].name, " illegal"}, illegal, tbl[k].ill);
         chk({tbl[k].name, " stores"}, nst - base, tbl[k].nst);
         if (tbl[k].nst > 0) begin
            chk({tbl[k].name, " data"}, st_data, tbl[k].data);
            chk({tbl[k].name, " addr"}, st_addr, tbl[k].addr);
         end
      end

      // Undefined opcode: HALT is terminal with no further fetches.
      prog = '{16'hE000, H, H, H, H};
      load(prog);
      run(10, cyc);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (imem_req || dmem_req || !halted || !illegal) bad++;
      end
      chk("illegal terminal", bad, 0);

      // Store with three wait states.
      prog = '{ei(1,0,1,31), ei(1,1,1,31), ei(1,1,1,28),
               ei(3,0,1,2), H};
      load(prog);
      dwait = 3;
      base = nst;
      cnt = 0;
      bad = 0;
      cyc = 0;
      do_reset();
      while (cyc < 60) begin
         tick();
         cyc++;
         if (dmem_req) begin
            cnt++;
            if (dmem_addr !== 16'h2 || dmem_wdata !== 16'h5A
                || dmem_we !== 1'b1) bad++;
         end
         if (halted) break;
      end
      dwait = 0;
      chk("sw wait req cycles", cnt, 4);
      chk("sw wait stable", bad, 0);
      chk("sw wait total", cyc, 21);
      chk("sw wait stores", nst - base, 1);
      chk("sw wait data", st_data, 16'h005A);

      // beq r0,r0,-1 loops at pc 0 every 3 cycles.
      prog = '{ei(4,0,0,-1), H, H, H, H};
      load(prog);
      do_reset();
      #1;
      chk("post-reset fetch", imem_req, 1'b1);
      bad = 0;
      cnt = 1;
      for (int c = 2; c <= 10; c++) begin
         tick();
         if (imem_req !== ((c - 1) % 3 == 0)) bad++;
         if (imem_req) begin
            cnt++;
            if (imem_addr !== 8'h00) bad++;
         end
      end
      chk("beq loop pattern", bad, 0);
      chk("beq loop fetches", cnt, 4);

      // j 0xFFF truncates to 0xFF, then pc wraps to 0.
      prog = '{ej(12'hFFF), H, H, H, H};
      load(prog);
      imem[255] = ei(1,0,1,1);
      do_reset();
      #1;
      repeat (3) tick();
      chk("j req", imem_req, 1'b1);
      chk("j target", imem_addr, 8'hFF);
      repeat (4) tick();
      chk("wrap req", imem_req, 1'b1);
      chk("wrap addr", imem_addr, 8'h00);

      // Reset during a data stall.
      prog = '{ei(3,0,0,0), H, H, H, H};
      load(prog);
      dwait = 1000;
      base = nst;
      seen = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dmem_req) begin
            seen = 1;
            break;
         end
      end
      chk("stall reached", seen, 1);
      tick();
      reset = 1'b0;
      #1;
      chk("rst dmem_req drop", dmem_req, 1'b0);
      chk("rst dmem_we drop", dmem_we, 1'b0);
      chk("rst pc", imem_addr, 8'h00);
      chk("rst no fetch", imem_req, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("release fetch", imem_req, 1'b1);
      chk("release addr", imem_addr, 8'h00);
      chk("aborted store", nst - base, 0);
      dwait = 0;

      chk("req overlap", overlap, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
